xsim_bus_arbiter: RTL and testbench

//  Sequential round-robin arbiter for xSimBus masters. It replaces the fixed-priority

---
 rtl/xsim_bus_arbiter_pkg.sv | 13 +
 rtl/xsim_rr_pick.sv | 36 +++
 rtl/xsim_bus_arbiter.sv | 119 +++++++++++
 tb/tb_xsim_bus_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/xsim_bus_arbiter_pkg.sv
// Shared constants and state encoding for the xSimBus round-robin arbiter.
package xsim_bus_arbiter_pkg;

  localparam int NO_MASTER_ID      = 31;
  localparam int ARB_BURST_DEFAULT = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/xsim_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module xsim_rr_pick #(
  parameter int DEV_NUM = 31,
  parameter int ID_W    = 5
) (
  input  logic [DEV_NUM-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    id,
  output logic [DEV_NUM-1:0] onehot
);
  import xsim_bus_arbiter_pkg::*;

  int              idx;
  logic [ID_W-1:0] idx_w;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    valid  = 1'b0;
    id     = ID_W'(NO_MASTER_ID);
    onehot = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < DEV_NUM; i++) begin
      idx = int'(ptr) + i;
      if (idx >= DEV_NUM) idx = idx - DEV_NUM;
      idx_w = ID_W'(idx);
      if (!valid && req[idx_w]) begin
        valid         = 1'b1;
        id            = idx_w;
        onehot[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xsim_bus_arbiter.sv
// Round-robin xSimBus arbiter: registered grant held per transaction, burst-limited
// preemption, and one TURN cycle between owners.
module xsim_bus_arbiter
  import xsim_bus_arbiter_pkg::*;
#(
  parameter int DEV_NUM   = 31,
  parameter int ID_W      = 5,
  parameter int MAX_BURST = ARB_BURST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DEV_NUM-1:0] devices_in,
  input  logic [DEV_NUM-1:0] lock_in,
  output logic [ID_W-1:0]    master_id_out,
  output logic [DEV_NUM-1:0] grant_out,
  output logic               hold_flag_out,
  output logic               preempt_out
);

  localparam int              CNT_W      = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  NONE_ID    = ID_W'(NO_MASTER_ID);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(DEV_NUM - 1);

  arb_state_e         state, state_d;
  logic [ID_W-1:0]    ptr, ptr_d;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_d;
  logic [ID_W-1:0]    id_d;
  logic [DEV_NUM-1:0] grant_d;
  logic               hold_d, preempt_d;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [DEV_NUM-1:0] pick_onehot;

  logic own_req, own_lock, others_req, burst_last, release_normal, release_preempt;

  xsim_rr_pick #(.DEV_NUM(DEV_NUM), .ID_W(ID_W)) u_pick (
    .req    (devices_in),
    .ptr    (ptr),
    .valid  (pick_valid),
    .id     (pick_id),
    .onehot (pick_onehot)
  );

  // Owner's request/lock are taken through the one-hot grant, so an idle id never indexes.
  assign own_req         = |(devices_in & grant_out);
  assign own_lock        = |(lock_in & grant_out);
  assign others_req      = |(devices_in & ~grant_out);
  assign burst_last      = (burst_cnt == BURST_LAST);
  assign release_normal  = !own_req;
  assign release_preempt = own_req && burst_last && !own_lock && others_req;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ARB_IDLE:  if (pick_valid) state_d = ARB_GRANT;
      ARB_GRANT: if (release_normal || release_preempt) state_d = ARB_TURN;
      ARB_TURN:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    id_d        = NONE_ID;
    grant_d     = '0;
    hold_d      = 1'b0;
    preempt_d   = 1'b0;
    ptr_d       = ptr;
    burst_cnt_d = burst_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          id_d        = pick_id;
          grant_d     = pick_onehot;
          hold_d      = 1'b1;
          burst_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (release_normal || release_preempt) begin
          ptr_d     = (master_id_out == LAST_ID) ? '0 : master_id_out + ID_W'(1);
          preempt_d = release_preempt;
        end else begin
          id_d        = master_id_out;
          grant_d     = grant_out;
          hold_d      = 1'b1;
          burst_cnt_d = burst_last ? burst_cnt : burst_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      burst_cnt     <= '0;
      master_id_out <= NONE_ID;
      grant_out     <= '0;
      hold_flag_out <= 1'b0;
      preempt_out   <= 1'b0;
    end else begin
      ptr           <= ptr_d;
      burst_cnt     <= burst_cnt_d;
      master_id_out <= id_d;
      grant_out     <= grant_d;
      hold_flag_out <= hold_d;
      preempt_out   <= preempt_d;
    end
  end

endmodule

// File: tb/tb_xsim_bus_arbiter.sv
// Directed bench for xsim_bus_arbiter with MAX_BURST=4 and hand-computed grant sequences.
module tb_xsim_bus_arbiter;

  localparam int DEV_NUM   = 31;
  localparam int ID_W      = 5;
  localparam int MAX_BURST = 4;
  localparam int NONE      = 31;

  logic               clk;
  logic               rst;
  logic [DEV_NUM-1:0] devices_in;
  logic [DEV_NUM-1:0] lock_in;
  logic [ID_W-1:0]    master_id_out;
  logic [DEV_NUM-1:0] grant_out;
  logic               hold_flag_out;
  logic               preempt_out;

  int errors = 0;
  int checks = 0;

  xsim_bus_arbiter #(.DEV_NUM(DEV_NUM), .ID_W(ID_W), .MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .devices_in    (devices_in),
    .lock_in       (lock_in),
    .master_id_out (master_id_out),
    .grant_out     (grant_out),
    .hold_flag_out (hold_flag_out),
    .preempt_out   (preempt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_bus(input string tag, input int exp_id, input bit exp_pre);
    logic [DEV_NUM-1:0] exp_grant;
    exp_grant = (exp_id == NONE) ? '0 : (DEV_NUM'(1) << exp_id);
    check({tag, ".id"},      32'(master_id_out), 32'(exp_id));
    check({tag, ".grant"},   32'(grant_out),     32'(exp_grant));
    check({tag, ".hold"},    32'(hold_flag_out), 32'(exp_id != NONE));
    check({tag, ".preempt"}, 32'(preempt_out),   32'(exp_pre));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq3_id  [13] = '{0, 0, 0, 0, NONE, NONE, 2, 2, 2, 2, NONE, NONE, 0};
  bit seq3_pre [13] = '{0, 0, 0, 0, 1,    0,    0, 0, 0, 0, 1,    0,    0};

  initial begin
    rst        = 1'b1;
    devices_in = '0;
    lock_in    = '0;
    #1;
    expect_bus("reset", NONE, 0);
    #22 rst = 1'b0;
    tick();
    expect_bus("idle_after_reset", NONE, 0);

    // Locked owner at burst limit keeps the bus; dropping the lock preempts it.
    lock_in    = 31'h1;
    devices_in = 31'h3;
    for (int k = 0; k < 20; k++) begin
      tick();
      expect_bus("lock_hold", 0, 0);
    end
    lock_in = '0;
    tick(); expect_bus("lock_drop_turn", NONE, 1);
    tick(); expect_bus("lock_drop_idle", NONE, 0);
    tick(); expect_bus("lock_next_owner", 1, 0);
    devices_in = '0;
    tick(); expect_bus("t4_end_turn", NONE, 0);
    tick(); expect_bus("t4_end_idle", NONE, 0);

    // Simple grant with 1-cycle latency and normal drop (ptr=2 here).
    devices_in = 31'h4;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_bus("basic_grant", 2, 0);
    end
    devices_in = '0;
    tick(); expect_bus("basic_turn", NONE, 0);
    tick(); expect_bus("basic_idle", NONE, 0);

    // Two contenders alternate at MAX_BURST with a preempt pulse each handover (ptr=3).
    devices_in = 31'h5;
    for (int k = 0; k < 13; k++) begin
      tick();
      expect_bus($sformatf("rr_seq%0d", k), seq3_id[k], seq3_pre[k]);
    end
    devices_in = '0;
    tick(); expect_bus("rr_end_turn", NONE, 0);
    tick(); expect_bus("rr_end_idle", NONE, 0);

    // Sole requester is never preempted past the burst limit (ptr=1).
    devices_in = 31'h20;
    for (int k = 0; k < 3 * MAX_BURST; k++) begin
      tick();
      expect_bus("solo_grant", 5, 0);
    end
    devices_in = '0;
    tick(); expect_bus("solo_turn", NONE, 0);
    tick(); expect_bus("solo_idle", NONE, 0);

    // Grant of the last id wraps ptr to 0, so bit 1 beats bit 30.
    devices_in = DEV_NUM'(1) << 30;
    tick(); expect_bus("wrap_grant30", 30, 0);
    devices_in = '0;
    tick(); expect_bus("wrap_turn", NONE, 0);
    devices_in = (DEV_NUM'(1) << 30) | 31'h2;
    tick(); expect_bus("wrap_idle", NONE, 0);
    tick(); expect_bus("wrap_pick1", 1, 0);

    // Owner drops while another request rises in the same cycle.
    devices_in = 31'h8;
    tick(); expect_bus("simul_turn", NONE, 0);
    tick(); expect_bus("simul_idle", NONE, 0);
    tick(); expect_bus("simul_grant3", 3, 0);
    tick(); expect_bus("simul_hold3", 3, 0);

    // Asynchronous reset mid-grant drops the bus immediately and clears ptr.
    #2 rst = 1'b1;
    #1 expect_bus("async_reset", NONE, 0);
    #1 rst = 1'b0;
    devices_in = 31'h9;
    tick(); expect_bus("post_reset_ptr0", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
